// File: rtl/pic10_gpio_pkg.sv
// pic10_gpio_pkg: shared constants and address decode helper for the
// pic10_gpio_bank GPIO block. Optional feature macro: PIC10_GPIO_IOC_EN.
package pic10_gpio_pkg;

    localparam int unsigned DEFAULT_BASE_ADDR = 5;

    // Reset values of the per-port registers (sliced to PORT_WIDTH by users)
    localparam logic [7:0] LAT_RST  = 8'h00;
    localparam logic [7:0] TRIS_RST = 8'hFF;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } port_hit_t;

    // Decode a file address into (hit, port index) for a bank of n ports at base
    function automatic port_hit_t port_hit(input logic [4:0]  addr,
                                           input int unsigned base,
                                           input int unsigned n);
        port_hit_t   r;
        int unsigned a;
        a     = {27'd0, addr};
        r.hit = (a >= base) && (a < base + n);
        r.idx = r.hit ? 3'(a - base) : 3'd0;
        return r;
    endfunction

endpackage

// File: rtl/pic10_gpio_bank_if.sv
// pic10_gpio_bank_if: CPU file-register access path into the GPIO bank.
// The master side is the CPU, the slave side is pic10_gpio_bank.
interface pic10_gpio_bank_if;

    logic [4:0] addr;
    logic       wr_en;
    logic       tris_wr;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;

    modport master (
        output addr, wr_en, tris_wr, wr_data, rd_en,
        input  rd_data
    );

    modport slave (
        input  addr, wr_en, tris_wr, wr_data, rd_en,
        output rd_data
    );

endinterface

// File: rtl/pic10_gpio_sync.sv
// pic10_gpio_sync: STAGES-deep, WIDTH-wide pin input synchroniser with
// asynchronous active-low reset. One instance per GPIO port.
module pic10_gpio_sync #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift the raw pin value through the synchroniser chain
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int unsigned s = 1; s < STAGES; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/pic10_gpio_bank.sv
// pic10_gpio_bank: parametrised GPIO bank on the pic10_cpu file-register
// path. Each port has an output latch, a TRIS direction register and a pin
// synchroniser; reads return the synchronised pins. Interrupt-on-change is
// built only when the macro PIC10_GPIO_IOC_EN is defined; otherwise irq is 0.
module pic10_gpio_bank
    import pic10_gpio_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = 3,
    parameter int unsigned PORT_WIDTH  = 8,
    parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    pic10_gpio_bank_if.slave                    bus,
    inout  wire [NUM_PORTS*PORT_WIDTH-1:0]      gpio_pin_bus,
    output logic                                irq
);

    port_hit_t             hit;
    logic [NUM_PORTS-1:0]  sel;
    logic [PORT_WIDTH-1:0] sync_val [NUM_PORTS];
    logic [7:0]            rd_mux;
`ifdef PIC10_GPIO_IOC_EN
    logic [NUM_PORTS-1:0]  flag_nxt;
`endif

    assign hit = port_hit(bus.addr, BASE_ADDR, NUM_PORTS);

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
        logic [PORT_WIDTH-1:0] lat_q, lat_d;
        logic [PORT_WIDTH-1:0] tris_q, tris_d;

        assign sel[k] = hit.hit && (hit.idx == 3'(k));

        // Latch and TRIS writes; both may be written in the same cycle
        always_comb begin
            lat_d  = lat_q;
            tris_d = tris_q;
            if (sel[k] && bus.wr_en) begin
                lat_d = bus.wr_data[PORT_WIDTH-1:0];
            end
            if (sel[k] && bus.tris_wr) begin
                tris_d = bus.wr_data[PORT_WIDTH-1:0];
            end
        end

        // Port state registers; reset leaves every pin as an input
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                lat_q  <= LAT_RST[PORT_WIDTH-1:0];
                tris_q <= TRIS_RST[PORT_WIDTH-1:0];
            end else begin
                lat_q  <= lat_d;
                tris_q <= tris_d;
            end
        end

        for (genvar i = 0; i < PORT_WIDTH; i++) begin : g_pin
            assign gpio_pin_bus[k*PORT_WIDTH+i] = tris_q[i] ? 1'bz : lat_q[i];
        end

        pic10_gpio_sync #(
            .WIDTH  (PORT_WIDTH),
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk_i  (clk),
            .rst_ni (reset),
            .d_i    (gpio_pin_bus[k*PORT_WIDTH +: PORT_WIDTH]),
            .q_o    (sync_val[k])
        );

`ifdef PIC10_GPIO_IOC_EN
        logic [PORT_WIDTH-1:0] snap_q, snap_d;
        logic                  flag_q, flag_d;

        // Change detect on input bits only; a read of the port re-arms it
        // and takes priority over a set in the same cycle
        always_comb begin
            snap_d = snap_q;
            flag_d = flag_q;
            if (((sync_val[k] ^ snap_q) & tris_q) != '0) begin
                flag_d = 1'b1;
            end
            if (sel[k] && bus.rd_en) begin
                snap_d = sync_val[k];
                flag_d = 1'b0;
            end
        end

        // Snapshot and change-flag registers
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                snap_q <= '0;
                flag_q <= 1'b0;
            end else begin
                snap_q <= snap_d;
                flag_q <= flag_d;
            end
        end

        assign flag_nxt[k] = flag_d;
`endif
    end

    // Read mux: synchronised pins of the addressed port, zero on a miss
    always_comb begin
        rd_mux = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (sel[k]) begin
                rd_mux[PORT_WIDTH-1:0] = sync_val[k];
            end
        end
    end

    assign bus.rd_data = rd_mux;

`ifdef PIC10_GPIO_IOC_EN
    logic irq_q;

    // irq registered from next-state flags so it tracks the flags edge for edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |flag_nxt;
        end
    end

    assign irq = irq_q;
`else
    logic unused_rd_en;
    assign unused_rd_en = bus.rd_en;
    assign irq          = 1'b0;
`endif

endmodule

// File: tb/tb_pic10_gpio_bank.sv
// tb_pic10_gpio_bank: directed self-checking bench for pic10_gpio_bank with
// 3 ports of 8 bits at file addresses 5..7. Pins have pull-ups and an
// external per-bit driver. IOC expectations follow PIC10_GPIO_IOC_EN.
module tb_pic10_gpio_bank;

`ifdef PIC10_GPIO_IOC_EN
    localparam logic EXP_IRQ = 1'b1;
`else
    localparam logic EXP_IRQ = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        irq;
    wire  [23:0] pins;
    logic [23:0] ext_oe;
    logic [23:0] ext_val;

    int unsigned n_tests;
    int unsigned n_fail;

    pic10_gpio_bank_if bus ();

    pic10_gpio_bank #(
        .NUM_PORTS   (3),
        .PORT_WIDTH  (8),
        .BASE_ADDR   (5),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .gpio_pin_bus (pins),
        .irq          (irq)
    );

    for (genvar i = 0; i < 24; i++) begin : g_pad
        pullup (pins[i]);
        assign pins[i] = ext_oe[i] ? ext_val[i] : 1'bz;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d, input logic we, input logic tw);
        bus.addr    = a;
        bus.wr_data = d;
        bus.wr_en   = we;
        bus.tris_wr = tw;
        tick(1);
        bus.wr_en   = 1'b0;
        bus.tris_wr = 1'b0;
    endtask

    task automatic rd_clr(input logic [4:0] a);
        bus.addr  = a;
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        reset       = 1'b0;
        ext_oe      = '0;
        ext_val     = '0;
        bus.addr    = 5'd5;
        bus.wr_en   = 1'b0;
        bus.tris_wr = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;

        // reset state
        tick(2);
        check("rst_pins", 32'(pins), 32'hFF_FFFF);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_rd5", 32'(bus.rd_data), 32'h00);
        reset = 1'b1;
        tick(1);
        check("sync_lat1", 32'(bus.rd_data), 32'h00);
        tick(1);
        check("sync_lat2", 32'(bus.rd_data), 32'hFF);
        bus.addr = 5'd6;
        #1;
        check("rd6_idle", 32'(bus.rd_data), 32'hFF);

        // output drive on port 1
        wr(5'd6, 8'hF0, 1'b0, 1'b1);
        check("tris_pins", 32'(pins[15:8]), 32'hF0);
        wr(5'd6, 8'h0A, 1'b1, 1'b0);
        check("lat_pins", 32'(pins[15:8]), 32'hFA);
        tick(1);
        check("rd6_lat1", 32'(bus.rd_data), 32'hF0);
        tick(1);
        check("rd6_lat2", 32'(bus.rd_data), 32'hFA);

        // simultaneous latch + TRIS write on port 2, then TRIS only
        wr(5'd7, 8'h0F, 1'b1, 1'b1);
        check("dual_pins", 32'(pins[23:16]), 32'h0F);
        wr(5'd7, 8'h00, 1'b0, 1'b1);
        check("dual_lat", 32'(pins[23:16]), 32'h0F);

        // out-of-range accesses
        wr(5'd8, 8'h55, 1'b1, 1'b1);
        check("oor_pins", 32'(pins), 32'h0F_FAFF);
        check("oor_rd8", 32'(bus.rd_data), 32'h00);
        bus.addr = 5'd4;
        #1;
        check("oor_rd4", 32'(bus.rd_data), 32'h00);
        bus.addr = 5'd7;
        tick(3);
        check("rd7", 32'(bus.rd_data), 32'h0F);

        // re-arm every port, irq must settle low
        check("irq_pre", 32'(irq), 32'(EXP_IRQ));
        rd_clr(5'd5);
        rd_clr(5'd6);
        rd_clr(5'd7);
        check("irq_clr0", 32'(irq), 32'h0);
        tick(1);
        check("irq_clr1", 32'(irq), 32'h0);

        // IOC: pull pin 5.3 low externally
        bus.addr   = 5'd5;
        ext_val[3] = 1'b0;
        ext_oe[3]  = 1'b1;
        tick(2);
        check("ioc_e2", 32'(irq), 32'h0);
        check("ioc_rd", 32'(bus.rd_data), 32'hF7);
        tick(1);
        check("ioc_e3", 32'(irq), 32'(EXP_IRQ));
        rd_clr(5'd5);
        check("ioc_rdclr", 32'(irq), 32'h0);
        tick(2);
        check("ioc_hold", 32'(irq), 32'h0);
        ext_oe[3] = 1'b0;
        tick(3);
        check("ioc_rise", 32'(irq), 32'(EXP_IRQ));
        rd_clr(5'd5);
        check("ioc_clr2", 32'(irq), 32'h0);

        // IOC mask: bit 0 of port 2 as output while toggling its latch
        wr(5'd7, 8'hFE, 1'b0, 1'b1);
        tick(3);
        rd_clr(5'd7);
        tick(1);
        check("mask_arm", 32'(irq), 32'h0);
        for (int unsigned r = 0; r < 3; r++) begin
            wr(5'd7, 8'h00, 1'b1, 1'b0);
            tick(2);
            check("mask_rd0", 32'(bus.rd_data), 32'hFE);
            check("mask_irq0", 32'(irq), 32'h0);
            wr(5'd7, 8'h01, 1'b1, 1'b0);
            tick(2);
            check("mask_rd1", 32'(bus.rd_data), 32'hFF);
            check("mask_irq1", 32'(irq), 32'h0);
        end

        // async reset with outputs driven and irq raised
        bus.addr   = 5'd5;
        ext_val[3] = 1'b0;
        ext_oe[3]  = 1'b1;
        tick(3);
        check("arst_pre_irq", 32'(irq), 32'(EXP_IRQ));
        check("arst_pre_pins", 32'(pins[15:8]), 32'hFA);
        @(posedge clk);
        #2;
        reset  = 1'b0;
        ext_oe = '0;
        #1;
        check("arst_pins", 32'(pins), 32'hFF_FFFF);
        check("arst_irq", 32'(irq), 32'h0);
        check("arst_rd", 32'(bus.rd_data), 32'h00);
        reset = 1'b1;
        tick(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pic10_gpio_bank.md
# pic10_gpio_bank

Parametrised GPIO bank for the `pic10_cpu` register file, replacing the fixed three 8-bit ports at file addresses 5–7. It provides NUM_PORTS ports of PORT_WIDTH bits, each with an output latch and a TRIS direction register, plus synchronised pin inputs. It optionally adds per-port interrupt-on-change with a single `irq` output. It sits on the CPU's file-register read/write path and drives the external pin buses.

## Interface
- NUM_PORTS, 3: number of ports, 1..8.
- PORT_WIDTH, 8: bits per port, 1..8; unused upper bits of `wr_data`/`rd_data` are ignored/read 0.
- BASE_ADDR, 5: file address of port 0; port k is at BASE_ADDR+k.
- SYNC_STAGES, 2: input synchroniser depth, ≥2.
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- addr  input  5  file-register address from CPU.
- wr_en  input  1  file write strobe, qualified by `addr`.
- tris_wr  input  1  TRIS instruction strobe, qualified by `addr`.
- wr_data  input  8  W/ALU data for latch or TRIS write.
- rd_en  input  1  file read strobe, used only for IOC snapshot.
- rd_data  output  8  combinational read data.
- gpio_pin_bus  inout  NUM_PORTS*PORT_WIDTH  pins; port k occupies bits [k*PORT_WIDTH +: PORT_WIDTH].
- irq  output  1  interrupt-on-change request.

## Operation
- Per port: `lat` (reset 0), `tris` (reset all 1 = input), synchroniser chain (reset 0).
- Pin drive: bit i = tris[i] ? 'z : lat[i]. After reset, all pins float.
- Address hit: BASE_ADDR ≤ addr < BASE_ADDR+NUM_PORTS. Misses are ignored; `rd_data` = 0 on a miss.
- `wr_en` on hit: `lat` ← wr_data[PORT_WIDTH-1:0] at the next edge, regardless of direction.
- `tris_wr` on hit: `tris` ← wr_data at the next edge.
- If `wr_en` and `tris_wr` are both active, both registers are written.
- `rd_data` returns the synchronised pin value, not `lat`. This gives PIC read-modify-write semantics: a read-back of an output reflects the pin after the synchroniser latency.
- IOC (macro-enabled): per-port `snap` (reset 0) and `flag` (reset 0).
  - Flag set: on an edge where (sync ^ snap) & tris ≠ 0.
  - `rd_en` on a hit for that port: `snap` ← sync value and `flag` ← 0 at the edge. Read-clear wins over a same-cycle set.
  - A mismatch persisting after the read sets the flag again on the following edge.
- `irq` = OR of all `flag`s, registered, glitch-free.
- Output-mode bits (tris=0) never set a flag.
- Reset mid-operation: all registers clear asynchronously. Pins tri-state immediately and `irq` drops immediately.

## Timing
- Latch/TRIS write: pin drive changes one edge after the strobe.
- Pin → `rd_data`: visible after SYNC_STAGES edges.
- Pin → `irq`: asserts SYNC_STAGES+1 edges after the pin change (flag register).
- Read-clear → `irq` low: one edge after the `rd_en` cycle.
- `rd_data` settles combinationally within the cycle of `addr`.

## Configuration
- Macro: `PIC10_GPIO_IOC_EN`.
- Defined: `snap`/`flag` logic present; `irq` behaves as specified.
- Undefined: no IOC registers; `irq` is tied 0; `rd_en` is unused.

## Structure
- Package `pic10_gpio_pkg`:
  - default BASE_ADDR;
  - reset constants (LAT_RST = 0, TRIS_RST = all-ones);
  - function `port_hit(addr, base, n)` returning hit flag and port index.
- Sub-module `pic10_gpio_sync`: SYNC_STAGES-deep, PORT_WIDTH-wide, async-reset synchroniser, one instance per port.
- Top level: generate loop over ports, address decode, read mux, IOC OR tree.

## Test plan
- Reset: after reset release, `tris`=0xFF, pins read 0xFF via pull-ups, `irq`=0, `rd_data` at addr 5 = 0xFF after 2 edges.
- Output drive: TRIS 0xF0 then write 0x0A to addr 6 → pins[15:8]=0xFA one edge later; read of addr 6 returns 0xFA after 2 more edges.
- Out-of-range: write 0x55 to addr 8 with NUM_PORTS=3 → no latch changes; `rd_data`=0.
- IOC: read addr 5, then external driver pulls pin 5.3 low → `irq` high 3 edges later; read addr 5 → `irq` low next edge; pin still low → stays low.
- IOC mask: tris bit 0 = 0 on port 7 while toggling the latch → `irq` never asserts.
- Async reset: assert `reset` low mid-cycle with outputs driven and `irq` high → pins float and `irq`=0 without waiting for `clk`.
